// File: rtl/pwm_duty_ramp_pkg.sv
// pwm_duty_ramp_pkg: shared state encoding and motor PWM defaults
package pwm_duty_ramp_pkg;
  localparam int PWM_PERIOD = 1000;
  localparam int PWM_CNT_W = 10;
  localparam int PWM_STEP = 50;
  localparam int PWM_DEAD_PERIODS = 2;
  typedef enum logic [1:0] {IDLE, RUN, RAMP_DOWN, DEADTIME} state_t;
endpackage

// File: rtl/pwm_slew_step.sv
// pwm_slew_step: saturating move of duty toward target by at most STEP
module pwm_slew_step #(
  parameter int CNT_W = 10,
  parameter int STEP = 50
) (
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] target,
  output logic [CNT_W-1:0] next
);
  localparam logic [CNT_W:0] S = STEP[CNT_W:0];
  logic [CNT_W:0] d, t, up, dn, sum;
  // widened arithmetic so neither direction can wrap
  always_comb begin
    d = {1'b0, duty};
    t = {1'b0, target};
    up = t - d;
    dn = d - t;
    sum = t > d ? d + (up > S ? S : up) : d - (dn > S ? S : dn);
  end
  assign next = sum[CNT_W-1:0] | {CNT_W{sum[CNT_W]}};
endmodule

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slew-limited duty ramp with direction dead-time driving the motor PWM
module pwm_duty_ramp
  import pwm_duty_ramp_pkg::*;
#(
  parameter int PERIOD = PWM_PERIOD,
  parameter int CNT_W = PWM_CNT_W,
  parameter int STEP = PWM_STEP,
  parameter int DEAD_PERIODS = PWM_DEAD_PERIODS
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [CNT_W-1:0] i_counter,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_target_duty,
  input  logic             i_dir,
  output logic             o_pwm,
  output logic             o_dir,
  output logic [CNT_W-1:0] o_duty,
  output logic             o_busy
);
  localparam logic [CNT_W-1:0] FULL = PERIOD[CNT_W-1:0];
  localparam logic [CNT_W-1:0] LAST = FULL - 1'b1;
  localparam int DW = $clog2(DEAD_PERIODS + 2);
  localparam logic [DW-1:0] DEAD = DEAD_PERIODS[DW-1:0];
  state_t state;
  logic [DW-1:0] dead, dead_nx;
  logic [CNT_W-1:0] tgt, step_tgt, next;
  logic pe, stop_req, go;
  // boundary detect, target clamp, and choice of slew target (zero while winding down)
  always_comb begin
    pe = i_counter == LAST;
    tgt = i_target_duty > FULL ? FULL : i_target_duty;
    stop_req = i_dir != o_dir || !i_enable;
    go = i_enable && tgt != '0;
    step_tgt = (state == RAMP_DOWN || (state == RUN && stop_req)) ? '0 : tgt;
    dead_nx = dead - 1'b1;
  end
  pwm_slew_step #(.CNT_W(CNT_W), .STEP(STEP)) u_step (
    .duty(o_duty),
    .target(step_tgt),
    .next(next)
  );
  assign o_busy = state == RAMP_DOWN || state == DEADTIME;
  // PWM compare every clock; duty, direction and state move only on period boundaries
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      dead <= '0;
      o_pwm <= 1'b0;
      o_dir <= 1'b0;
      o_duty <= '0;
    end else begin
      o_pwm <= i_counter < o_duty;
      if (pe) begin
        case (state)
          IDLE: begin
            o_dir <= i_dir;
            if (go) begin
              state <= RUN;
              o_duty <= next;
            end
          end
          RUN: begin
            o_duty <= next;
            if (stop_req) state <= RAMP_DOWN;
          end
          RAMP_DOWN: begin
            o_duty <= next;
            if (next == '0) begin
              if (DEAD_PERIODS == 0) begin
                o_dir <= i_dir;
                state <= go ? RUN : IDLE;
              end else begin
                state <= DEADTIME;
                dead <= DEAD;
              end
            end
          end
          DEADTIME: begin
            dead <= dead_nx;
            if (dead_nx == '0) begin
              o_dir <= i_dir;
              state <= go ? RUN : IDLE;
            end
          end
        endcase
      end
    end
  end
endmodule
